serv_rd_deser: RTL and testbench

Bit-serial-to-parallel collector for the SERV datapath's result stream. It receives the 1-bit-per-cycle `rd` stream that the bit-serial ALU produces, LSB first, and assembles it into a 32-bit word. It generates the `cnt0` first-bit strobe that the ALU consumes, and captures the final compare flag. It sits between the ALU result output and any parallel consumer (debug port, trace unit, CSR shadow), and presents the result over a valid/ready handshake.

---
 rtl/serv_rd_deser.sv | 137 +++++++++++++
 tb/tb_serv_rd_deser.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_rd_deser.sv
// serv_rd_deser: collects the SERV bit-serial result stream (LSB first) into a
// 32-bit word, generates the ALU first-bit strobe and presents the result over
// a valid/ready handshake.
//
// Optional feature macro: SERV_RD_DESER_CMP_EN
//   defined   -> i_cmp is captured on the last qualified bit and drives o_cmp
//   undefined -> no capture register, o_cmp tied low, i_cmp unused
module serv_rd_deser #(
    parameter int B = 0,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_en,
    input  logic [W-1:0] i_rd,
    input  logic         i_cmp,
    output logic         o_cnt0,
    output logic         o_busy,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [31:0]  o_data,
    output logic         o_cmp,
    output logic         o_overrun
);

    // Only the single-lane, bit-0 configuration is implemented.
    generate
        if (B != 0) begin : g_bad_b
            $error("serv_rd_deser: only B=0 is supported");
        end
        if (W != 1) begin : g_bad_w
            $error("serv_rd_deser: only W=1 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [31:0] sr, sr_n;
    logic        overrun_n;
    logic        overrun_q;
    logic        last_bit;

    // Next-state, counter, shift register and overrun detection.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sr_n      = sr;
        overrun_n = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_n = SHIFT;
                    cnt_n   = 5'd0;
                end
            end
            SHIFT: begin
                // A start request while collecting is dropped and flagged.
                if (i_start) overrun_n = 1'b1;
                if (i_en) begin
                    sr_n  = {i_rd[B], sr[31:1]};
                    cnt_n = cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state_n  = HOLD;
                        last_bit = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (i_ready) begin
                    // Accept and restart in the same cycle keeps transfers back-to-back.
                    if (i_start) begin
                        state_n = SHIFT;
                        cnt_n   = 5'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (i_start) begin
                    overrun_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 5'd0;
            end
        endcase
    end

    // State, counter, shift register and overrun pulse registers.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            sr        <= 32'd0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sr        <= sr_n;
            overrun_q <= overrun_n;
        end
    end

`ifdef SERV_RD_DESER_CMP_EN
    logic cmp_q;

    // Compare flag is taken together with bit 31 and held until the next word.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            cmp_q <= 1'b0;
        end else if (last_bit) begin
            cmp_q <= i_cmp;
        end
    end

    assign o_cmp = cmp_q;
`else
    logic unused_cmp;
    assign unused_cmp = i_cmp ^ last_bit;
    assign o_cmp      = 1'b0;
`endif

    assign o_busy    = (state == SHIFT);
    assign o_cnt0    = (state == SHIFT) && (cnt == 5'd0);
    assign o_valid   = (state == HOLD);
    // sr only moves in SHIFT, so it is stable for the whole HOLD period.
    assign o_data    = sr;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_serv_rd_deser.sv
// Directed bench for serv_rd_deser: reset, basic word, stalls, backpressure
// with back-to-back restart, overrun and reset mid-transfer.
module tb_serv_rd_deser;

    logic        clk;
    logic        i_rst_n;
    logic        i_start;
    logic        i_en;
    logic [0:0]  i_rd;
    logic        i_cmp;
    logic        o_cnt0;
    logic        o_busy;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_cmp;
    logic        o_overrun;

    int checks = 0;
    int errors = 0;

    serv_rd_deser #(.B(0), .W(1)) dut (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_en      (i_en),
        .i_rd      (i_rd),
        .i_cmp     (i_cmp),
        .o_cnt0    (o_cnt0),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_cmp     (o_cmp),
        .o_overrun (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_cmp(input logic c);
`ifdef SERV_RD_DESER_CMP_EN
        return c;
`else
        return 1'b0;
`endif
    endfunction

    // Stream 32 bits from SHIFT state. stall=1 puts i_en low first, then alternates.
    task automatic shift_bits(input logic [31:0] w, input logic cmpb, input bit stall,
                              input int ovr_at, inout int lat, inout int ovr_cnt);
        int k = 0;
        int c = 0;
        bit en;
        while (k < 32) begin
            en      = stall ? c[0] : 1'b1;
            i_en    = en;
            i_rd[0] = w[k];
            i_cmp   = (k == 31) ? cmpb : ~cmpb;
            i_start = (k == ovr_at) && en;
            checks++;
            if (o_cnt0 !== (k == 0)) begin
                errors++;
                $display("FAIL cnt0 bit %0d: got %b expected %b", k, o_cnt0, (k == 0));
            end
            checks++;
            if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
                errors++;
                $display("FAIL shifting bit %0d: busy=%b valid=%b expected busy=1 valid=0",
                         k, o_busy, o_valid);
            end
            step;
            lat++;
            c++;
            if (o_overrun === 1'b1) ovr_cnt++;
            if (en) k++;
        end
        i_en    = 1'b0;
        i_start = 1'b0;
        i_cmp   = 1'b0;
        i_rd    = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [31:0] w, input logic cmpb);
        checks++;
        if (o_valid !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s valid: got valid=%b busy=%b expected valid=1 busy=0",
                     name, o_valid, o_busy);
        end
        checks++;
        if (o_data !== w) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, o_data, w);
        end
        checks++;
        if (o_cmp !== exp_cmp(cmpb)) begin
            errors++;
            $display("FAIL %s cmp: got %b expected %b", name, o_cmp, exp_cmp(cmpb));
        end
    endtask

    task automatic accept(input string name);
        i_ready = 1'b1;
        step;
        i_ready = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: got valid=%b busy=%b expected 0 0", name, o_valid, o_busy);
        end
    endtask

    task automatic start_xfer(output int lat);
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        lat = 1;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        i_start = 1'b1;
        step;
        step;
        checks++;
        if ({o_valid, o_busy, o_cnt0, o_overrun, o_cmp} !== 5'b0 || o_data !== 32'd0) begin
            errors++;
            $display("FAIL reset: got v=%b b=%b c0=%b ov=%b cmp=%b data=%h expected all 0",
                     o_valid, o_busy, o_cnt0, o_overrun, o_cmp, o_data);
        end
        i_start = 1'b0;
        i_rst_n = 1'b1;
        step;
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset release: got busy=%b valid=%b expected 0 0", o_busy, o_valid);
        end
    endtask

    task automatic test_basic;
        int lat;
        int ov = 0;
        start_xfer(lat);
        shift_bits(32'hA5C3_0F17, 1'b1, 1'b0, -1, lat, ov);
        checks++;
        if (lat != 33) begin
            errors++;
            $display("FAIL basic latency: got %0d expected 33", lat);
        end
        check_result("basic", 32'hA5C3_0F17, 1'b1);
        accept("basic");
    endtask

    task automatic test_stall;
        int lat;
        int ov = 0;
        start_xfer(lat);
        shift_bits(32'hA5C3_0F17, 1'b0, 1'b1, -1, lat, ov);
        checks++;
        if (lat != 65) begin
            errors++;
            $display("FAIL stall latency: got %0d expected 65", lat);
        end
        check_result("stall", 32'hA5C3_0F17, 1'b0);
        accept("stall");
    endtask

    task automatic test_back_to_back;
        int lat;
        int ov = 0;
        start_xfer(lat);
        shift_bits(32'h5A3C_96E1, 1'b1, 1'b0, -1, lat, ov);
        for (int i = 0; i < 10; i++) begin
            i_start = (i == 4);
            step;
            checks++;
            if (o_valid !== 1'b1 || o_data !== 32'h5A3C_96E1) begin
                errors++;
                $display("FAIL hold cycle %0d: got valid=%b data=%h expected 1 5a3c96e1",
                         i, o_valid, o_data);
            end
            checks++;
            if (o_overrun !== (i == 4)) begin
                errors++;
                $display("FAIL hold overrun cycle %0d: got %b expected %b", i, o_overrun, (i == 4));
            end
        end
        i_start = 1'b1;
        i_ready = 1'b1;
        step;
        i_start = 1'b0;
        i_ready = 1'b0;
        lat = 1;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b1 || o_cnt0 !== 1'b1 || o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b restart: got v=%b b=%b c0=%b ov=%b expected 0 1 1 0",
                     o_valid, o_busy, o_cnt0, o_overrun);
        end
        shift_bits(32'h0000_0001, 1'b0, 1'b0, -1, lat, ov);
        checks++;
        if (lat != 33) begin
            errors++;
            $display("FAIL b2b latency: got %0d expected 33", lat);
        end
        check_result("b2b", 32'h0000_0001, 1'b0);
        accept("b2b");
    endtask

    task automatic test_overrun;
        int lat;
        int ov = 0;
        start_xfer(lat);
        shift_bits(32'h1357_9BDF, 1'b1, 1'b0, 5, lat, ov);
        checks++;
        if (ov != 1) begin
            errors++;
            $display("FAIL overrun pulses: got %0d expected 1", ov);
        end
        check_result("overrun", 32'h1357_9BDF, 1'b1);
        accept("overrun");
    endtask

    task automatic test_reset_mid;
        int lat;
        int ov = 0;
        bit seen = 0;
        start_xfer(lat);
        i_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            i_rd = 1'b1;
            step;
        end
        i_rst_n = 1'b0;
        i_start = 1'b1;
        step;
        i_rst_n = 1'b1;
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_cnt0 !== 1'b0 || o_data !== 32'd0) begin
            errors++;
            $display("FAIL reset mid: got b=%b v=%b c0=%b data=%h expected 0 0 0 0",
                     o_busy, o_valid, o_cnt0, o_data);
        end
        for (int i = 0; i < 40; i++) begin
            i_rd = 1'b1;
            step;
            if (o_valid === 1'b1 || o_busy === 1'b1) seen = 1;
        end
        i_en = 1'b0;
        i_rd = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset mid idle: got valid/busy activity expected none");
        end
        start_xfer(lat);
        shift_bits(32'hFFFF_FFFF, 1'b1, 1'b0, -1, lat, ov);
        check_result("fresh", 32'hFFFF_FFFF, 1'b1);
        accept("fresh");
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_en    = 1'b0;
        i_rd    = 1'b0;
        i_cmp   = 1'b0;
        i_ready = 1'b0;
        test_reset;
        test_basic;
        test_stall;
        test_back_to_back;
        test_overrun;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
